// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the memory game round controller.
// Holds the FSM state encoding, cell mask helper and default widths.
package memory_game_pkg;

  localparam int DEF_MAX_SIDE = 5;
  localparam int DEF_N        = DEF_MAX_SIDE * DEF_MAX_SIDE;
  localparam int DEF_LIVES    = 3;
  localparam int SIDE_W       = $clog2(DEF_MAX_SIDE + 1);
  localparam int LIFE_W       = $clog2(DEF_LIVES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_INPUT,
    S_JUDGE,
    S_OVER
  } state_e;

  // Low side*side bits set: the active cells of a side x side grid.
  function automatic logic [DEF_N-1:0] side_mask(input int side);
    logic [DEF_N-1:0] m;
    m = '0;
    for (int i = 0; i < DEF_N; i++) begin
      if (i < side * side) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/memory_game_engine_timer.sv
// Loadable down-counter timing the target display window.
// done is high while the count is exhausted.
module game_show_timer #(
  parameter int CYCLES = 100,
  localparam int CW = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  output logic done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(CYCLES - 1);
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/memory_game_engine.sv
// Round controller for the memory game: load, show, guess, judge,
// with combo/score/lives bookkeeping and automatic grid growth.
module memory_game_engine
  import memory_game_pkg::*;
#(
  parameter int MAX_SIDE    = DEF_MAX_SIDE,
  parameter int LIVES       = DEF_LIVES,
  parameter int SHOW_CYCLES = 100,
  parameter int LEVEL_UP    = 4,
  parameter int SCORE_W     = 12,
  parameter int COMBO_W     = 8,
  localparam int N    = MAX_SIDE * MAX_SIDE,
  localparam int LV_W = $clog2(MAX_SIDE - 1),
  localparam int SW   = $clog2(MAX_SIDE + 1),
  localparam int LW   = $clog2(LIVES + 1),
  localparam int RW   = $clog2(LEVEL_UP + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic [LV_W-1:0]    level,
  input  logic [N-1:0]       pattern,
  input  logic               pattern_valid,
  input  logic [N-1:0]       guess,
  input  logic               guess_valid,
  output logic               show,
  output logic [N-1:0]       target,
  output logic               answer,
  output logic               wrong,
  output logic [COMBO_W-1:0] o_combo,
  output logic [SCORE_W-1:0] o_score,
  output logic [LW-1:0]      o_life,
  output logic [SW-1:0]      o_side,
  output logic               game_over
);

  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  state_e             state_q, state_d;
  logic [N-1:0]       target_q, target_d;
  logic               show_q, show_d;
  logic               answer_q, answer_d;
  logic               wrong_q, wrong_d;
  logic               correct_q, correct_d;
  logic               over_q, over_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LW-1:0]      life_q, life_d;
  logic [SW-1:0]      side_q, side_d;
  logic [RW-1:0]      rounds_q, rounds_d;

  logic [N-1:0]       mask;
  logic [COMBO_W-1:0] combo_inc;
  logic               tmr_start, tmr_en, tmr_done;
  int                 sum;
  int                 lv_side;

  assign mask      = N'(side_mask(int'(side_q)));
  assign combo_inc = (&combo_q) ? combo_q : combo_q + 1'b1;
  assign tmr_en    = en && (state_q == S_SHOW);

  game_show_timer #(
    .CYCLES(SHOW_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .start(tmr_start),
    .en   (tmr_en),
    .done (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    show_d    = show_q;
    answer_d  = answer_q;
    wrong_d   = wrong_q;
    correct_d = correct_q;
    over_d    = over_q;
    combo_d   = combo_q;
    score_d   = score_q;
    life_d    = life_q;
    side_d    = side_q;
    rounds_d  = rounds_q;
    tmr_start = 1'b0;
    sum       = 0;
    lv_side   = int'(level) + 2;
    if (lv_side < 3)        lv_side = 3;
    if (lv_side > MAX_SIDE) lv_side = MAX_SIDE;
    if (en) begin
      answer_d = 1'b0;
      wrong_d  = 1'b0;
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            combo_d  = '0;
            score_d  = '0;
            life_d   = LW'(LIVES);
            rounds_d = '0;
            side_d   = SW'(lv_side);
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          if (pattern_valid) begin
            target_d  = pattern & mask;
            tmr_start = 1'b1;
            state_d   = S_SHOW;
          end
        end
        S_SHOW: begin
          if (tmr_done) state_d = S_INPUT;
        end
        S_INPUT: begin
          if (guess_valid) begin
            correct_d = ((guess & mask) == target_q);
            state_d   = S_JUDGE;
          end
        end
        S_JUDGE: begin
          if (correct_q) begin
            answer_d = 1'b1;
            combo_d  = combo_inc;
            sum = int'(score_q) + int'(side_q) * int'(side_q)
                + int'(combo_inc);
            score_d  = (sum > SCORE_MAX) ? '1 : SCORE_W'(sum);
            if (int'(rounds_q) + 1 == LEVEL_UP) begin
              rounds_d = '0;
              if (side_q < SW'(MAX_SIDE)) side_d = side_q + 1'b1;
            end else begin
              rounds_d = rounds_q + 1'b1;
            end
            state_d = S_LOAD;
          end else begin
            wrong_d = 1'b1;
            combo_d = '0;
            life_d  = life_q - 1'b1;
            state_d = (life_q == LW'(1)) ? S_OVER : S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
      show_d = (state_d == S_SHOW);
      over_d = (state_d == S_OVER);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      show_q    <= 1'b0;
      answer_q  <= 1'b0;
      wrong_q   <= 1'b0;
      correct_q <= 1'b0;
      over_q    <= 1'b0;
      combo_q   <= '0;
      score_q   <= '0;
      life_q    <= LW'(LIVES);
      side_q    <= SW'(3);
      rounds_q  <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      show_q    <= show_d;
      answer_q  <= answer_d;
      wrong_q   <= wrong_d;
      correct_q <= correct_d;
      over_q    <= over_d;
      combo_q   <= combo_d;
      score_q   <= score_d;
      life_q    <= life_d;
      side_q    <= side_d;
      rounds_q  <= rounds_d;
    end
  end

  assign show      = show_q;
  assign target    = target_q;
  assign answer    = answer_q;
  assign wrong     = wrong_q;
  assign o_combo   = combo_q;
  assign o_score   = score_q;
  assign o_life    = life_q;
  assign o_side    = side_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_memory_game_engine.sv
// Randomized bench for memory_game_engine with a transaction-level
// reference model compared against every output on every cycle.
module tb_memory_game_engine;

  localparam int N = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    level = '0;
  logic [N-1:0]  pattern = '0;
  logic          pattern_valid = 1'b0;
  logic [N-1:0]  guess = '0;
  logic          guess_valid = 1'b0;
  logic          show, answer, wrong, game_over;
  logic [N-1:0]  target;
  logic [7:0]    o_combo;
  logic [11:0]   o_score;
  logic [1:0]    o_life;
  logic [2:0]    o_side;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit rand_en = 1'b0;
  int show_cnt = 0;

  bit           m_show, m_answer, m_wrong, m_over;
  logic [N-1:0] m_target;
  int           m_combo, m_score, m_life, m_side, m_rounds;

  memory_game_engine #(
    .MAX_SIDE(5), .LIVES(3), .SHOW_CYCLES(100),
    .LEVEL_UP(4), .SCORE_W(12), .COMBO_W(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .level(level), .pattern(pattern),
    .pattern_valid(pattern_valid), .guess(guess),
    .guess_valid(guess_valid), .show(show), .target(target),
    .answer(answer), .wrong(wrong), .o_combo(o_combo),
    .o_score(o_score), .o_life(o_life), .o_side(o_side),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("show",      32'(show),      32'(m_show));
      chk("target",    32'(target),    32'(m_target));
      chk("answer",    32'(answer),    32'(m_answer));
      chk("wrong",     32'(wrong),     32'(m_wrong));
      chk("combo",     32'(o_combo),   32'(m_combo));
      chk("score",     32'(o_score),   32'(m_score));
      chk("life",      32'(o_life),    32'(m_life));
      chk("side",      32'(o_side),    32'(m_side));
      chk("game_over", 32'(game_over), 32'(m_over));
      if (show) show_cnt++;
    end
  end

  function automatic logic [N-1:0] mmask(input int s);
    logic [63:0] one;
    one = 64'd1;
    return N'((one << (s * s)) - 64'd1);
  endfunction

  function automatic logic [N-1:0] rnd();
    return N'($urandom);
  endfunction

  task automatic model_reset();
    m_show = 0; m_target = '0; m_answer = 0; m_wrong = 0;
    m_combo = 0; m_score = 0; m_life = 3; m_side = 3;
    m_over = 0; m_rounds = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled edge, optionally preceded by a frozen (en=0) cycle
  // carrying junk valid pulses that must be lost.
  task automatic etick();
    logic pv, gv;
    if (rand_en && $urandom_range(0, 7) == 0) begin
      pv = pattern_valid;
      gv = guess_valid;
      en = 1'b0;
      pattern_valid = 1'($urandom);
      guess_valid = 1'($urandom);
      tick();
      pattern_valid = pv;
      guess_valid = gv;
      en = 1'b1;
    end
    tick();
    m_answer = 0;
    m_wrong = 0;
  endtask

  task automatic start_game(input int lv);
    int s;
    level = 2'(lv);
    start = 1'b1;
    etick();
    start = 1'b0;
    level = 2'($urandom);
    s = lv + 2;
    if (s < 3) s = 3;
    if (s > 5) s = 5;
    m_side = s; m_combo = 0; m_score = 0;
    m_life = 3; m_rounds = 0; m_over = 0;
  endtask

  task automatic load(input logic [N-1:0] pat);
    repeat ($urandom_range(0, 2)) etick();
    pattern = pat;
    pattern_valid = 1'b1;
    etick();
    pattern_valid = 1'b0;
    pattern = rnd();
    m_target = pat & mmask(m_side);
    m_show = 1;
  endtask

  task automatic show_phase();
    repeat (99) begin
      guess_valid = 1'($urandom);
      guess = rnd();
      etick();
    end
    etick();
    guess_valid = 1'b0;
    m_show = 0;
  endtask

  task automatic judge(input logic [N-1:0] g);
    bit ok;
    repeat ($urandom_range(0, 2)) etick();
    guess = g;
    guess_valid = 1'b1;
    etick();
    guess_valid = 1'b0;
    guess = rnd();
    etick();
    ok = ((g & mmask(m_side)) == m_target);
    if (ok) begin
      m_answer = 1;
      if (m_combo < 255) m_combo++;
      m_score = m_score + m_side * m_side + m_combo;
      if (m_score > 4095) m_score = 4095;
      m_rounds++;
      if (m_rounds == 4) begin
        m_rounds = 0;
        if (m_side < 5) m_side++;
      end
    end else begin
      m_wrong = 1;
      m_combo = 0;
      m_life--;
      if (m_life == 0) m_over = 1;
    end
  endtask

  task automatic play_round(input logic [N-1:0] pat, input bit good);
    logic [N-1:0] mk, g;
    load(pat);
    show_phase();
    mk = mmask(m_side);
    if (good) begin
      g = (pat & mk) | (rnd() & ~mk);
    end else begin
      g = pat;
      g[$urandom_range(0, m_side * m_side - 1)] ^= 1'b1;
    end
    judge(g);
  endtask

  task automatic finish_game();
    for (int k = 0; k < 4 && !m_over; k++) play_round(rnd(), 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_side", 32'(o_side), 32'd3);
    chk("rst_life", 32'(o_life), 32'd3);
    reset = 1'b0;
    etick();

    // Deterministic game, no enable gaps.
    start_game(1);
    show_cnt = 0;
    load(25'h1A5);
    show_phase();
    chk("show_len", 32'(show_cnt), 32'd100);
    judge(25'h1A5);
    chk("a1_answer", 32'(answer), 32'd1);
    chk("a1_combo", 32'(o_combo), 32'd1);
    chk("a1_score", 32'(o_score), 32'd10);
    chk("a1_life", 32'(o_life), 32'd3);
    load(25'h1A5);
    show_phase();
    judge(25'h1A4);
    chk("w1_wrong", 32'(wrong), 32'd1);
    chk("w1_combo", 32'(o_combo), 32'd0);
    chk("w1_life", 32'(o_life), 32'd2);
    load(25'h1A5);
    show_phase();
    judge(25'h1FFFFA5);
    chk("garb_answer", 32'(answer), 32'd1);
    chk("garb_score", 32'(o_score), 32'd20);
    play_round(25'h1A5, 1'b0);
    play_round(25'h1A5, 1'b0);
    chk("over", 32'(game_over), 32'd1);
    chk("over_score", 32'(o_score), 32'd20);
    etick();
    chk("held_score", 32'(o_score), 32'd20);

    // Level-up, wider mask, start ignored in INPUT.
    start_game(0);
    repeat (4) play_round(rnd(), 1'b1);
    chk("lvl_side", 32'(o_side), 32'd4);
    load(25'h1FFFFFF);
    chk("mask16", 32'(target), 32'h000FFFF);
    show_phase();
    start = 1'b1;
    level = 2'd3;
    etick();
    start = 1'b0;
    judge(25'h000FFFF);
    chk("after_start_ign", 32'(answer), 32'd1);

    // Reset during SHOW while frozen.
    load(rnd());
    repeat (10) etick();
    en = 1'b0;
    reset = 1'b1;
    tick();
    model_reset();
    chk("mid_rst_show", 32'(show), 32'd0);
    chk("mid_rst_target", 32'(target), 32'd0);
    chk("mid_rst_score", 32'(o_score), 32'd0);
    reset = 1'b0;
    en = 1'b1;
    etick();

    // Long streak to saturate the score, with enable gaps.
    rand_en = 1'b1;
    start_game(3);
    repeat (75) play_round(rnd(), 1'b1);
    chk("sat_score", 32'(o_score), 32'hFFF);
    finish_game();

    // Random games.
    repeat (3) begin
      start_game($urandom_range(0, 3));
      for (int r = 0; r < 10 && !m_over; r++) begin
        play_round(rnd(), $urandom_range(0, 2) != 0);
      end
      finish_game();
    end

    etick();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_game_engine.md
# memory_game_engine

Parametrised round controller for the memory game: latches a target cell pattern, shows it for a fixed time, accepts one player guess per round, judges it, and maintains combo, score, lives and grid size. It generalises the fixed 3x3/4x4/5x5 game brain to any square grid up to MAX_SIDE. It adds a timed show phase, automatic level-up, and an explicit game-over state. It sits between the pattern generator and the display/input front end.

## Interface
- MAX_SIDE, 5: largest grid side; N = MAX_SIDE*MAX_SIDE cells
- LIVES, 3: lives at game start
- SHOW_CYCLES, 100: cycles the target is displayed
- LEVEL_UP, 4: total correct rounds per automatic side increase
- SCORE_W, 12: score width
- COMBO_W, 8: combo width
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en  in  1  global enable; 0 freezes all state, counters and outputs
- start  in  1  begin new game (honoured in IDLE and OVER only)
- level  in  LV_W=$clog2(MAX_SIDE-1)  start level; side = level+2, clamped to 3..MAX_SIDE
- pattern  in  N  target bitmap, row-major, bit 0 = top-left
- pattern_valid  in  1  pattern present (sampled in LOAD)
- guess  in  N  player bitmap
- guess_valid  in  1  guess submission (button)
- show  out  1  high while target is displayed
- target  out  N  latched, masked target
- answer  out  1  one-cycle pulse: guess correct
- wrong  out  1  one-cycle pulse: guess incorrect
- o_combo  out  COMBO_W  consecutive correct rounds
- o_score  out  SCORE_W  score
- o_life  out  $clog2(LIVES+1)  lives remaining
- o_side  out  $clog2(MAX_SIDE+1)  current grid side
- game_over  out  1  high in OVER

## Operation
- States: IDLE, LOAD, SHOW, INPUT, JUDGE, OVER.
- IDLE/OVER + start: clear combo and score, set life=LIVES, clear the correct-round counter, set side from the clamped level, go to LOAD.
- LOAD: wait for pattern_valid. Latch target = pattern & mask(side), where mask has the low side*side bits set. Go to SHOW.
- SHOW: show=1 for exactly SHOW_CYCLES cycles, then go to INPUT. guess_valid is ignored in SHOW.
- INPUT: wait for guess_valid. Register correct = ((guess & mask) == target). Go to JUDGE. Bits of guess outside the mask are ignored.
- JUDGE, correct:
  - answer pulse; combo+1, saturating.
  - score += side*side + new combo, saturating at all-ones.
  - correct-round counter+1; on reaching LEVEL_UP, clear it and increment side if side < MAX_SIDE.
  - Go to LOAD.
- JUDGE, wrong:
  - wrong pulse; combo=0; life-1.
  - If the new life is 0, go to OVER; otherwise go to LOAD.
- OVER: game_over=1. Score and side are held until start.
- level is sampled only when a game is started.
- start outside IDLE/OVER is ignored.

## Timing
- Reset values: state IDLE, show 0, target 0, answer 0, wrong 0, o_combo 0, o_score 0, o_life LIVES, o_side 3, game_over 0.
- All outputs are registered.
- LOAD→SHOW: target is valid the cycle after pattern_valid.
- show rises the cycle after pattern_valid and stays high for SHOW_CYCLES cycles.
- guess_valid at cycle t: answer/wrong high at t+2 for one cycle; combo, score, life and side update in that same cycle.
- Reset asserted mid-game takes priority over everything, including en=0: the next cycle shows reset values.
- en=0 during SHOW stretches the show window.
- A guess_valid or pattern_valid pulse that occurs while en=0 is lost.
- Score saturation: at most one step per judge.

## Structure
- Package memory_game_pkg holds:
  - the state enum;
  - function side_mask(side) returning N bits;
  - the side and life width constants.
- Sub-module game_show_timer: a loadable down-counter with start/en/done that times the SHOW phase.
- Everything else (FSM, judge, scoring) lives in memory_game_engine.

## Test plan
- Reset, then start with level=1, pattern_valid with pattern=9'h1A5, then guess=9'h1A5:
  - show high 100 cycles;
  - answer pulse; o_combo=1, o_score=10, o_life=3.
- Same game, guess=9'h1A4 → wrong pulse, o_combo=0, o_life=2. A third wrong guess → game_over=1, o_score held.
- Four correct rounds at side 3 → o_side=4 after the 4th judge. The next target is masked to 16 bits: pattern bits above bit 15 read as 0 in target.
- Guess with a correct masked region plus garbage above bit 8 at side 3 → answer (the garbage is ignored). guess_valid pulsed during SHOW → ignored, no judge.
- Force score near all-ones (12'hFFC) and answer correctly at side 3 → o_score=12'hFFF.
- Reset asserted during SHOW with en=0 → all outputs at reset values on the next cycle. Start while in INPUT → ignored.
